// File: rtl/seg7_pkg.sv
// Shared glyph tables and helpers for the multiplexed 7-segment driver.
package seg7_pkg;

  localparam int unsigned MAX_DIGITS = 32;

  // Active-high glyphs, {a,b,c,d,e,f,g} with a as MSB
  localparam logic [6:0] SEG_OFF = 7'h00;
  localparam logic [6:0] GLYPH_0 = 7'h7E;
  localparam logic [6:0] GLYPH_1 = 7'h30;
  localparam logic [6:0] GLYPH_2 = 7'h6D;
  localparam logic [6:0] GLYPH_3 = 7'h79;
  localparam logic [6:0] GLYPH_4 = 7'h33;
  localparam logic [6:0] GLYPH_5 = 7'h5B;
  localparam logic [6:0] GLYPH_6 = 7'h1F;
  localparam logic [6:0] GLYPH_7 = 7'h70;
  localparam logic [6:0] GLYPH_8 = 7'h7F;
  localparam logic [6:0] GLYPH_9 = 7'h73;

  localparam logic [6:0] GLYPH_HEX_A = 7'h77;
  localparam logic [6:0] GLYPH_HEX_B = 7'h1F;
  localparam logic [6:0] GLYPH_HEX_C = 7'h4E;
  localparam logic [6:0] GLYPH_HEX_D = 7'h3D;
  localparam logic [6:0] GLYPH_HEX_E = 7'h4F;
  localparam logic [6:0] GLYPH_HEX_F = 7'h47;

  localparam logic [6:0] GLYPH_LEG_A = 7'h0D;
  localparam logic [6:0] GLYPH_LEG_B = 7'h19;
  localparam logic [6:0] GLYPH_LEG_C = 7'h23;
  localparam logic [6:0] GLYPH_LEG_D = 7'h4B;
  localparam logic [6:0] GLYPH_LEG_E = 7'h0F;
  localparam logic [6:0] GLYPH_LEG_F = 7'h00;

  // One-hot digit enable; out-of-range index yields all zeros
  function automatic logic [MAX_DIGITS-1:0] onehot(input int unsigned idx, input int unsigned n);
    onehot = '0;
    if (idx < n) onehot = MAX_DIGITS'(1) << idx;
  endfunction

endpackage

// File: rtl/seg7_scan_mux_hex7_decode.sv
// Nibble to active-high 7-segment glyph, hex or legacy glyph set for codes 10-15.
module hex7_decode
  import seg7_pkg::*;
#(
  parameter bit HEX_MODE = 1'b1
) (
  input  logic [3:0] nibble,
  output logic [6:0] glyph_c
);

  always_comb begin
    glyph_c = SEG_OFF;
    case (nibble)
      4'h0: glyph_c = GLYPH_0;
      4'h1: glyph_c = GLYPH_1;
      4'h2: glyph_c = GLYPH_2;
      4'h3: glyph_c = GLYPH_3;
      4'h4: glyph_c = GLYPH_4;
      4'h5: glyph_c = GLYPH_5;
      4'h6: glyph_c = GLYPH_6;
      4'h7: glyph_c = GLYPH_7;
      4'h8: glyph_c = GLYPH_8;
      4'h9: glyph_c = GLYPH_9;
      4'hA: glyph_c = HEX_MODE ? GLYPH_HEX_A : GLYPH_LEG_A;
      4'hB: glyph_c = HEX_MODE ? GLYPH_HEX_B : GLYPH_LEG_B;
      4'hC: glyph_c = HEX_MODE ? GLYPH_HEX_C : GLYPH_LEG_C;
      4'hD: glyph_c = HEX_MODE ? GLYPH_HEX_D : GLYPH_LEG_D;
      4'hE: glyph_c = HEX_MODE ? GLYPH_HEX_E : GLYPH_LEG_E;
      4'hF: glyph_c = HEX_MODE ? GLYPH_HEX_F : GLYPH_LEG_F;
      default: glyph_c = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/seg7_scan_mux.sv
// N-digit multiplexed 7-segment driver: shadow capture, prescaled scan with dead time,
// leading-zero blanking and pin-polarity output registers.
module seg7_scan_mux
  import seg7_pkg::*;
#(
  parameter int unsigned N_DIGITS       = 4,
  parameter int unsigned DIV_WIDTH      = 16,
  parameter bit          HEX_MODE       = 1'b1,
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter bit          AN_ACTIVE_LOW  = 1'b1,
  parameter bit          LZ_BLANK       = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [4*N_DIGITS-1:0] value,
  input  logic [N_DIGITS-1:0]   dp_in,
  input  logic [N_DIGITS-1:0]   blank_in,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [N_DIGITS-1:0]   an
);

  localparam int unsigned      IDX_W    = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_DIGITS - 1);
  localparam logic [6:0]       SEG_IDLE = SEG_ACTIVE_LOW ? ~SEG_OFF : SEG_OFF;
  localparam logic             DP_IDLE  = SEG_ACTIVE_LOW;
  localparam logic [N_DIGITS-1:0] AN_IDLE = AN_ACTIVE_LOW ? {N_DIGITS{1'b1}} : '0;

  logic [DIV_WIDTH-1:0]  cnt;
  logic [IDX_W-1:0]      idx, idx_nxt;
  logic                  dead, dead_nxt;
  logic                  scan_on, scan_on_nxt;
  logic [4*N_DIGITS-1:0] sh_val;
  logic [N_DIGITS-1:0]   sh_dp, sh_blank;
  logic                  tick_c;
  logic [N_DIGITS-1:0]   lz_mask;
  logic                  lz_run;
  logic [3:0]            nib_c;
  logic [6:0]            glyph_c;
  logic                  show_c;
  logic [6:0]            seg_c;
  logic                  dp_c;
  logic [N_DIGITS-1:0]   an_c;

  assign tick_c = &cnt;

  // Scan sequencing; the first tick after reset selects digit 0 rather than advancing
  always_comb begin
    idx_nxt     = idx;
    dead_nxt    = 1'b0;
    scan_on_nxt = scan_on;
    if (tick_c) begin
      dead_nxt    = 1'b1;
      scan_on_nxt = 1'b1;
      if (!scan_on || idx == LAST_IDX) idx_nxt = '0;
      else                             idx_nxt = idx + IDX_W'(1);
    end
  end

  // Leading-zero run from the top digit; a digit with dp set joins the run but ends it
  always_comb begin
    lz_mask = '0;
    lz_run  = LZ_BLANK;
    for (int i = N_DIGITS - 1; i >= 1; i--) begin
      if (lz_run && sh_val[4*i +: 4] == 4'h0) begin
        lz_mask[i] = 1'b1;
        lz_run     = !sh_dp[i];
      end else begin
        lz_run = 1'b0;
      end
    end
  end

  assign nib_c = sh_val[4*32'(idx_nxt) +: 4];

  hex7_decode #(.HEX_MODE(HEX_MODE)) u_decode (
    .nibble  (nib_c),
    .glyph_c (glyph_c)
  );

  // Output values track the scan state being entered, so pins and dead flag align
  always_comb begin
    show_c = scan_on_nxt && !dead_nxt;
    seg_c  = SEG_OFF;
    dp_c   = 1'b0;
    an_c   = '0;
    if (show_c) begin
      an_c = N_DIGITS'(onehot(32'(idx_nxt), N_DIGITS));
      if (!sh_blank[idx_nxt]) begin
        seg_c = lz_mask[idx_nxt] ? SEG_OFF : glyph_c;
        dp_c  = sh_dp[idx_nxt];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt      <= '0;
      idx      <= '0;
      dead     <= 1'b0;
      scan_on  <= 1'b0;
      sh_val   <= '0;
      sh_dp    <= '0;
      sh_blank <= '0;
      seg      <= SEG_IDLE;
      dp       <= DP_IDLE;
      an       <= AN_IDLE;
    end else begin
      cnt     <= cnt + DIV_WIDTH'(1);
      idx     <= idx_nxt;
      dead    <= dead_nxt;
      scan_on <= scan_on_nxt;
      if (load) begin
        sh_val   <= value;
        sh_dp    <= dp_in;
        sh_blank <= blank_in;
      end
      seg <= SEG_ACTIVE_LOW ? ~seg_c : seg_c;
      dp  <= SEG_ACTIVE_LOW ? ~dp_c : dp_c;
      an  <= AN_ACTIVE_LOW ? ~an_c : an_c;
    end
  end

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Bench for seg7_scan_mux: hex, legacy and no-blanking variants against a cycle-count model.
module tb_seg7_scan_mux;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        load = 1'b0;
  logic [15:0] value = '0;
  logic [3:0]  dp_in = '0;
  logic [3:0]  blank_in = '0;
  logic [6:0]  seg_v [3];
  logic        dp_v  [3];
  logic [3:0]  an_v  [3];

  int unsigned compared = 0;
  int unsigned mismatched = 0;

  always #5 clk = ~clk;

  // dut 0: hex + blanking, dut 1: legacy + blanking, dut 2: hex without blanking
  seg7_scan_mux #(.N_DIGITS(4), .DIV_WIDTH(2), .HEX_MODE(1'b1), .SEG_ACTIVE_LOW(1'b1),
                  .AN_ACTIVE_LOW(1'b1), .LZ_BLANK(1'b1)) dut_hex (
    .clk(clk), .reset(reset), .load(load), .value(value), .dp_in(dp_in), .blank_in(blank_in),
    .seg(seg_v[0]), .dp(dp_v[0]), .an(an_v[0]));
  seg7_scan_mux #(.N_DIGITS(4), .DIV_WIDTH(2), .HEX_MODE(1'b0), .SEG_ACTIVE_LOW(1'b1),
                  .AN_ACTIVE_LOW(1'b1), .LZ_BLANK(1'b1)) dut_leg (
    .clk(clk), .reset(reset), .load(load), .value(value), .dp_in(dp_in), .blank_in(blank_in),
    .seg(seg_v[1]), .dp(dp_v[1]), .an(an_v[1]));
  seg7_scan_mux #(.N_DIGITS(4), .DIV_WIDTH(2), .HEX_MODE(1'b1), .SEG_ACTIVE_LOW(1'b1),
                  .AN_ACTIVE_LOW(1'b1), .LZ_BLANK(1'b0)) dut_nolz (
    .clk(clk), .reset(reset), .load(load), .value(value), .dp_in(dp_in), .blank_in(blank_in),
    .seg(seg_v[2]), .dp(dp_v[2]), .an(an_v[2]));

  localparam logic [6:0] GL_HEX [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h1F, 7'h70,
                                          7'h7F, 7'h73, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};
  localparam logic [6:0] GL_LEG [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h1F, 7'h70,
                                          7'h7F, 7'h73, 7'h0D, 7'h19, 7'h23, 7'h4B, 7'h0F, 7'h00};

  // Model state: edges since reset, and the captured word the current outputs are built from
  int unsigned n = 0;
  logic [15:0] shadow_val = '0, cur_val = '0;
  logic [3:0]  shadow_dp = '0, cur_dp = '0, shadow_blank = '0, cur_blank = '0;

  always @(posedge clk) begin
    if (reset) begin
      n = 0;
      shadow_val = '0; shadow_dp = '0; shadow_blank = '0;
      cur_val = '0; cur_dp = '0; cur_blank = '0;
    end else begin
      n++;
      cur_val = shadow_val; cur_dp = shadow_dp; cur_blank = shadow_blank;
      if (load) begin
        shadow_val = value; shadow_dp = dp_in; shadow_blank = blank_in;
      end
    end
  end

  // Ticks every 4 edges from the 4th; the k-th tick starts digit (k-1) mod 4 after one dead cycle
  function automatic logic [11:0] expect_out(input bit hexm, input bit lz);
    int d;
    bit inrun;
    logic [3:0] nib;
    logic [6:0] s;
    logic p;
    if (n < 5 || n % 4 == 0) return {4'hF, 7'h7F, 1'b1};
    d = int'((n / 4 - 1) % 4);
    inrun = lz && d > 0;
    for (int j = 3; j >= d; j--) begin
      if (((cur_val >> (4 * j)) & 16'hF) != 16'h0) inrun = 0;
      if (j > d && cur_dp[j]) inrun = 0;
    end
    nib = 4'((cur_val >> (4 * d)) & 16'hF);
    s = hexm ? GL_HEX[nib] : GL_LEG[nib];
    p = cur_dp[d];
    if (inrun) s = 7'h00;
    if (cur_blank[d]) begin s = 7'h00; p = 1'b0; end
    return {~(4'b0001 << d), ~s, ~p};
  endfunction

  // Segment content during the anti-ghost cycle is not defined; only anodes are compared there
  function automatic logic [11:0] expect_mask();
    return (n >= 4 && n % 4 == 0) ? 12'hF00 : 12'hFFF;
  endfunction

  function automatic logic [11:0] obs(input int v);
    return {an_v[v], seg_v[v], dp_v[v]};
  endfunction

  task automatic test_reset();
    int first = 0;
    reset = 1'b1; load = 1'b0;
    repeat (3) begin
      @(negedge clk);
      compared++;
      if (obs(0) !== 12'hFFF) begin
        mismatched++; $display("FAIL reset_hold got=%h expected=fff", obs(0));
      end
    end
    reset = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      for (int v = 0; v < 3; v++) begin
        compared++;
        if ((obs(v) & expect_mask()) !== (expect_out(v != 1, v != 2) & expect_mask())) begin
          mismatched++;
          $display("FAIL reset_release dut%0d n=%0d got=%h expected=%h", v, n, obs(v), expect_out(v != 1, v != 2));
        end
      end
      if (first == 0 && an_v[0] !== 4'hF) begin
        first = c;
        compared++;
        if (an_v[0] !== 4'b1110) begin
          mismatched++; $display("FAIL first_enable_digit got=%b expected=1110", an_v[0]);
        end
      end
    end
    compared++;
    if (first != 5) begin
      mismatched++; $display("FAIL first_enable_latency got=%0d expected=5", first);
    end
  endtask

  task automatic test_pattern(input string tag, input logic [15:0] val, input logic [3:0] dpv,
                              input logic [3:0] blk, input int cycles);
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      for (int v = 0; v < 3; v++) begin
        compared++;
        if ((obs(v) & expect_mask()) !== (expect_out(v != 1, v != 2) & expect_mask())) begin
          mismatched++;
          $display("FAIL %s dut%0d n=%0d got=%h expected=%h", tag, v, n, obs(v), expect_out(v != 1, v != 2));
        end
      end
      load = (c == 0);
      if (c == 0) begin value = val; dp_in = dpv; blank_in = blk; end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      for (int v = 0; v < 3; v++) begin
        compared++;
        if ((obs(v) & expect_mask()) !== (expect_out(v != 1, v != 2) & expect_mask())) begin
          mismatched++;
          $display("FAIL random dut%0d n=%0d got=%h expected=%h", v, n, obs(v), expect_out(v != 1, v != 2));
        end
      end
      load = ($urandom_range(0, 3) == 0);
      for (int k = 0; k < 4; k++)
        value[4*k +: 4] = ($urandom_range(0, 1) == 1) ? 4'h0 : 4'($urandom_range(0, 15));
      dp_in    = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
      blank_in = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
    end
    load = 1'b0;
  endtask

  task automatic test_load_on_tick();
    bit found = 0;
    load = 1'b0;
    for (int c = 0; c < 16 && !found; c++) begin
      @(negedge clk);
      if (n % 4 == 3) found = 1;
    end
    compared++;
    if (!found) begin
      mismatched++; $display("FAIL load_on_tick_wait got=timeout expected=tick");
    end
    value = 16'hFFFF; dp_in = 4'h0; blank_in = 4'h0; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    compared++;
    if (an_v[0] !== 4'hF) begin
      mismatched++; $display("FAIL load_on_tick_dead got=%b expected=1111", an_v[0]);
    end
    @(negedge clk);
    compared++;
    if (seg_v[0] !== 7'h38 || an_v[0] === 4'hF) begin
      mismatched++; $display("FAIL load_on_tick_hex got seg=%h an=%b expected seg=38 an=enabled", seg_v[0], an_v[0]);
    end
    compared++;
    if (seg_v[1] !== 7'h7F) begin
      mismatched++; $display("FAIL load_on_tick_legacy got seg=%h expected=7f", seg_v[1]);
    end
  endtask

  task automatic test_reset_mid();
    bit found = 0;
    for (int c = 0; c < 40 && !found; c++) begin
      @(negedge clk);
      if (an_v[0] === 4'b1011) found = 1;
    end
    compared++;
    if (!found) begin
      mismatched++; $display("FAIL reset_mid_wait got=timeout expected=digit2");
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int v = 0; v < 3; v++) begin
      compared++;
      if (obs(v) !== 12'hFFF) begin
        mismatched++; $display("FAIL reset_mid_idle dut%0d got=%h expected=fff", v, obs(v));
      end
    end
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      for (int v = 0; v < 3; v++) begin
        compared++;
        if ((obs(v) & expect_mask()) !== (expect_out(v != 1, v != 2) & expect_mask())) begin
          mismatched++;
          $display("FAIL reset_mid_restart dut%0d n=%0d got=%h expected=%h", v, n, obs(v), expect_out(v != 1, v != 2));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_pattern("digits_1234", 16'h1234, 4'h0, 4'h0, 24);
    test_pattern("lz_00a0", 16'h00A0, 4'h0, 4'h0, 20);
    test_pattern("dp_0005", 16'h0005, 4'b0010, 4'h0, 20);
    test_pattern("blank_0005", 16'h0005, 4'h0, 4'b0001, 20);
    test_load_on_tick();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
